// File: rtl/writeback_m.sv
// Register-file write-side controller: in-order result queue fed by load/ALU handshakes,
// drained one entry per cycle into the single write port, with pending-write busy flags.
module writeback_m #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [31:0]                mem_data,
    input  logic [4:0]                 mem_rd,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [31:0]                alu_data,
    input  logic [4:0]                 alu_rd,
    output logic [31:0]                writeData,
    output logic [4:0]                 writeRegister,
    output logic                       RegWrite,
    input  logic [4:0]                 register1,
    input  logic [4:0]                 register2,
    output logic                       busy1,
    output logic                       busy2,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   data_q [DEPTH];
    logic [4:0]    rd_q   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          full;
    logic          mem_fire;
    logic          alu_fire;
    logic [4:0]    in_rd;
    logic [31:0]   in_data;
    logic          push;
    logic          pop;

    // Handshake: a transfer completes on a cycle where valid and ready are both high at
    // the rising edge. Ready depends only on the registered count and on mem_valid (load
    // priority), never on the same-cycle pop, so at most one result is taken per cycle.
    assign full      = (count == CW'(DEPTH));
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign mem_fire  = mem_valid && mem_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign in_rd     = mem_fire ? mem_rd   : alu_rd;
    assign in_data   = mem_fire ? mem_data : alu_data;

    // Writes to register 0 complete the handshake but are dropped here.
    assign push = (mem_fire || alu_fire) && (in_rd != 5'd0);
    assign pop  = (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail] <= in_data;
            rd_q[tail]   <= in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            RegWrite      <= 1'b0;
            writeData     <= '0;
            writeRegister <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                writeData     <= data_q[head];
                writeRegister <= rd_q[head];
                head          <= head + PW'(1);
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Only entries still in the queue count; the one on the output registers is committing now.
    always_comb begin
        logic [PW-1:0] idx;
        busy1 = 1'b0;
        busy2 = 1'b0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if ((register1 != 5'd0) && (rd_q[idx] == register1)) busy1 = 1'b1;
                if ((register2 != 5'd0) && (rd_q[idx] == register2)) busy2 = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_writeback_m.sv
// Bench for writeback_m: directed scenarios plus randomized traffic against a queue model.
module tb_writeback_m;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [31:0]   mem_data = '0;
    logic [4:0]    mem_rd = '0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [31:0]   alu_data = '0;
    logic [4:0]    alu_rd = '0;
    logic [31:0]   writeData;
    logic [4:0]    writeRegister;
    logic          RegWrite;
    logic [4:0]    register1 = '0;
    logic [4:0]    register2 = '0;
    logic          busy1;
    logic          busy2;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    writeback_m #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data), .mem_rd(mem_rd),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data), .alu_rd(alu_rd),
        .writeData(writeData), .writeRegister(writeRegister), .RegWrite(RegWrite),
        .register1(register1), .register2(register2), .busy1(busy1), .busy2(busy2),
        .count(count)
    );

    // Reference model: pending writes in acceptance order, plus last value on the write port.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t        model_q[$];
    logic        exp_we = 1'b0;
    logic [31:0] exp_wd = '0;
    logic [4:0]  exp_wr = '0;
    bit          acc_mem;
    bit          acc_alu;
    int          tests_run = 0;
    int          failures = 0;

    function automatic logic model_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (model_q[i]) if (model_q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_mem_ready();
        return model_q.size() < DEPTH;
    endfunction

    function automatic logic model_alu_ready();
        return (model_q.size() < DEPTH) && !mem_valid;
    endfunction

    task automatic model_reset();
        model_q.delete();
        exp_we = 1'b0;
        exp_wd = '0;
        exp_wr = '0;
    endtask

    // Advance one clock and the model alongside it; ends 1 time unit after the edge.
    task automatic tick();
        bit   full;
        ent_t e;
        ent_t h;
        full    = (model_q.size() == DEPTH);
        acc_mem = mem_valid && !full;
        acc_alu = alu_valid && !full && !mem_valid;
        e.rd    = acc_mem ? mem_rd : alu_rd;
        e.data  = acc_mem ? mem_data : alu_data;
        @(posedge clk);
        if (model_q.size() > 0) begin
            h = model_q.pop_front();
            exp_we = 1'b1;
            exp_wd = h.data;
            exp_wr = h.rd;
        end else begin
            exp_we = 1'b0;
        end
        if ((acc_mem || acc_alu) && e.rd != 5'd0) model_q.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (RegWrite !== 1'b0 || writeData !== 32'h0 || writeRegister !== 5'h0) begin
            failures++;
            $display("FAIL reset_outputs: got we=%b wd=%h wr=%0d, expected 0/0/0", RegWrite, writeData, writeRegister);
        end
        tests_run++;
        if (count !== '0 || mem_ready !== 1'b1 || alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got count=%0d mr=%b ar=%b, expected 0/1/1", count, mem_ready, alu_ready);
        end
        mem_valid = 1'b1;
        #1;
        tests_run++;
        if (alu_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_alu_ready_mv: got %b expected 0", alu_ready);
        end
        mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single_alu();
        register1 = 5'd5;
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'h0000_00AA;
        #1;
        tests_run++;
        if (busy1 !== 1'b0 || alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_pre: got busy1=%b ar=%b expected 0/1", busy1, alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        #1;
        tests_run++;
        if (RegWrite !== 1'b0 || count !== CW'(1) || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL single_queued: got we=%b count=%0d busy1=%b expected 0/1/1", RegWrite, count, busy1);
        end
        tick();
        tests_run++;
        if (RegWrite !== 1'b1 || writeRegister !== 5'd5 || writeData !== 32'hAA || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL single_write: got we=%b wr=%0d wd=%h busy1=%b expected 1/5/aa/0", RegWrite, writeRegister, writeData, busy1);
        end
        tick();
        tests_run++;
        if (RegWrite !== 1'b0 || writeData !== 32'hAA || count !== '0) begin
            failures++;
            $display("FAIL single_after: got we=%b wd=%h count=%0d expected 0/aa/0", RegWrite, writeData, count);
        end
    endtask

    task automatic test_priority();
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h1111;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h2222;
        #1;
        tests_run++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL prio_ready: got ar=%b mr=%b expected 0/1", alu_ready, mem_ready);
        end
        tick();
        mem_valid = 1'b0;
        #1;
        tests_run++;
        if (alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL prio_alu_ready_next: got %b expected 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        tests_run++;
        if (RegWrite !== 1'b1 || writeRegister !== 5'd3 || writeData !== 32'h1111) begin
            failures++;
            $display("FAIL prio_first: got we=%b wr=%0d wd=%h expected 1/3/1111", RegWrite, writeRegister, writeData);
        end
        tick();
        tests_run++;
        if (RegWrite !== 1'b1 || writeRegister !== 5'd4 || writeData !== 32'h2222) begin
            failures++;
            $display("FAIL prio_second: got we=%b wr=%0d wd=%h expected 1/4/2222", RegWrite, writeRegister, writeData);
        end
        tick();
        tests_run++;
        if (RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle: got we=%b expected 0", RegWrite);
        end
    endtask

    task automatic test_rd_zero();
        register1 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        #1;
        tests_run++;
        if (alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd0_ready: got %b expected 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBEEF;
        tick();
        mem_valid = 1'b0;
        tests_run++;
        if (count !== '0 || busy1 !== 1'b0 || RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL rd0_queue: got count=%0d busy1=%b we=%b expected 0/0/0", count, busy1, RegWrite);
        end
        tick();
        tests_run++;
        if (RegWrite !== 1'b0 || writeData !== exp_wd) begin
            failures++;
            $display("FAIL rd0_nowrite: got we=%b wd=%h expected 0/%h", RegWrite, writeData, exp_wd);
        end
    endtask

    task automatic test_back_to_back();
        int nxt = 1;
        int want = 1;
        int pulses = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            alu_valid = (nxt <= 6);
            alu_rd    = 5'(nxt);
            alu_data  = 32'h100 + 32'(nxt);
            tick();
            if (acc_alu) nxt++;
            tests_run++;
            if (count > CW'(DEPTH) || count !== CW'(model_q.size())) begin
                failures++;
                $display("FAIL b2b_count: got %0d expected %0d", count, model_q.size());
            end
            if (RegWrite === 1'b1) begin
                tests_run++;
                if (writeRegister !== 5'(want) || writeData !== 32'h100 + 32'(want)) begin
                    failures++;
                    $display("FAIL b2b_order: got wr=%0d wd=%h expected %0d/%h", writeRegister, writeData, want, 32'h100 + 32'(want));
                end
                want++;
                pulses++;
            end
        end
        alu_valid = 1'b0;
        tests_run++;
        if (pulses != 6 || nxt != 7) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d pulses, %0d accepted, expected 6/6", pulses, nxt - 1);
        end
    endtask

    task automatic test_same_rd();
        register1 = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
        tick();
        alu_data = 32'h2;
        #1;
        tests_run++;
        if (busy1 !== 1'b1) begin
            failures++;
            $display("FAIL same_busy_a: got %b expected 1", busy1);
        end
        tick();
        alu_valid = 1'b0;
        #1;
        tests_run++;
        if (RegWrite !== 1'b1 || writeData !== 32'h1 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL same_first: got we=%b wd=%h busy1=%b expected 1/1/1", RegWrite, writeData, busy1);
        end
        tick();
        tests_run++;
        if (RegWrite !== 1'b1 || writeRegister !== 5'd7 || writeData !== 32'h2 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL same_second: got we=%b wr=%0d wd=%h busy1=%b expected 1/7/2/0", RegWrite, writeRegister, writeData, busy1);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        register1 = 5'd10;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        alu_rd = 5'd10; alu_data = 32'hA0;
        tick();
        alu_valid = 1'b0;
        tests_run++;
        if (RegWrite !== 1'b1 || count !== CW'(1)) begin
            failures++;
            $display("FAIL rstmid_pre: got we=%b count=%0d expected 1/1", RegWrite, count);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (RegWrite !== 1'b0 || writeData !== 32'h0 || writeRegister !== 5'h0 || count !== '0 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: got we=%b wd=%h wr=%0d count=%0d busy1=%b expected all 0", RegWrite, writeData, writeRegister, count, busy1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (RegWrite !== 1'b0 || count !== '0) begin
                failures++;
                $display("FAIL rstmid_stale: got we=%b count=%0d expected 0/0", RegWrite, count);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] pick [4];
        pick[0] = 5'd0; pick[1] = 5'd2; pick[2] = 5'd17; pick[3] = 5'd31;
        for (int cyc = 0; cyc < 400; cyc++) begin
            mem_valid = ($urandom_range(0, 3) == 0);
            mem_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : pick[$urandom_range(1, 3)];
            mem_data  = $urandom;
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            register1 = pick[$urandom_range(0, 3)];
            register2 = 5'($urandom_range(0, 31));
            #1;
            tests_run++;
            if (mem_ready !== model_mem_ready() || alu_ready !== model_alu_ready() ||
                busy1 !== model_busy(register1) || busy2 !== model_busy(register2)) begin
                failures++;
                $display("FAIL rand_comb: got mr=%b ar=%b b1=%b b2=%b expected %b/%b/%b/%b", mem_ready, alu_ready, busy1, busy2,
                         model_mem_ready(), model_alu_ready(), model_busy(register1), model_busy(register2));
            end
            tick();
            tests_run++;
            if (RegWrite !== exp_we || writeData !== exp_wd || writeRegister !== exp_wr || count !== CW'(model_q.size())) begin
                failures++;
                $display("FAIL rand_write: got we=%b wd=%h wr=%0d count=%0d expected %b/%h/%0d/%0d", RegWrite, writeData, writeRegister, count,
                         exp_we, exp_wd, exp_wr, model_q.size());
            end
        end
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_priority();
        test_rd_zero();
        test_back_to_back();
        test_same_rd();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
